// File: rtl/cross_bar_slave_arbiter.sv
// rtl/cross_bar_slave_arbiter.sv - per-slave round-robin arbiter with ack/abandon/watchdog release
// Grant is held until ack, requester drop or watchdog expiry; release hands over with no bubble.
module cross_bar_slave_arbiter #(
  parameter int MASTER_N    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int ID_W        = $clog2(MASTER_N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MASTER_N-1:0] req_i,
  input  logic                ack_i,
  output logic [MASTER_N-1:0] gnt_o,
  output logic [ID_W-1:0]     gnt_id_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam bit          WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [15:0] CNT_LAST = 16'(WDOG_EN ? TIMEOUT_CYC - 1 : 0);

  logic [0:0]          state;
  logic [ID_W-1:0]     ptr;
  logic [15:0]         cnt;

  logic [ID_W-1:0]     nxt_ptr;
  logic [ID_W-1:0]     start;
  logic [MASTER_N-1:0] cand;
  logic [ID_W-1:0]     idx;
  logic [ID_W-1:0]     win;
  logic                found;
  logic [MASTER_N-1:0] win_oh;
  logic                owner_req;
  logic                expire;
  logic                release_now;

  assign nxt_ptr     = (gnt_id_o == ID_W'(MASTER_N - 1)) ? '0 : gnt_id_o + ID_W'(1);
  assign owner_req   = req_i[gnt_id_o];
  assign expire      = WDOG_EN && (cnt == CNT_LAST);
  assign release_now = ack_i || !owner_req || expire;
  assign busy_o      = (state == BUSY);

  // On handover the current owner is masked and the search restarts just past it.
  assign start = (state == BUSY) ? nxt_ptr : ptr;
  assign cand  = (state == BUSY) ? (req_i & ~gnt_o) : req_i;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < MASTER_N; k++) begin
      idx = ID_W'((int'(start) + k) % MASTER_N);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh = {{(MASTER_N-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      gnt_id_o  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BUSY;
            gnt_o    <= win_oh;
            gnt_id_o <= win;
            cnt      <= '0;
          end
        end
        default: begin
          if (release_now) begin
            ptr       <= nxt_ptr;
            cnt       <= '0;
            // Only a pure watchdog release reports timeout; ack and abandon take precedence.
            timeout_o <= !ack_i && owner_req && expire;
            if (found) begin
              gnt_o    <= win_oh;
              gnt_id_o <= win;
            end else begin
              state    <= IDLE;
              gnt_o    <= '0;
              gnt_id_o <= '0;
            end
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// tb/tb_cross_bar_slave_arbiter.sv - scoreboard bench for cross_bar_slave_arbiter
// A behavioural model pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_cross_bar_slave_arbiter;

  localparam int N    = 4;
  localparam int TOUT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit busy;
    int owner;
    bit timeout;
  } exp_t;

  exp_t exp_q[$];

  cross_bar_slave_arbiter #(.MASTER_N(N), .TIMEOUT_CYC(TOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .ack_i     (ack),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, required);
    end
  endtask

  // First requesting master in round-robin order starting at 'start'.
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++)
      if (r[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  // Reference model: ownership, pointer and wait count as plain integers.
  int m_busy = 0, m_owner = 0, m_ptr = 0, m_cnt = 0;

  initial begin
    forever begin
      exp_t e;
      bit released;
      @(posedge clk);
      e.timeout = 0;
      if (rst) begin
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_busy == 0) begin
        if (req != 0) begin
          m_owner = pick(req, m_ptr);
          m_busy  = 1;
          m_cnt   = 0;
        end
      end else begin
        released = 0;
        if (ack) released = 1;
        else if (!req[m_owner]) released = 1;
        else if (TOUT != 0 && m_cnt == TOUT - 1) begin
          released  = 1;
          e.timeout = 1;
        end else m_cnt++;
        if (released) begin
          logic [N-1:0] others;
          others = req;
          others[m_owner] = 1'b0;
          m_ptr = (m_owner + 1) % N;
          m_cnt = 0;
          if (others != 0) m_owner = pick(others, m_ptr);
          else m_busy = 0;
        end
      end
      e.busy  = (m_busy != 0);
      e.owner = m_owner;
      exp_q.push_back(e);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_busy", int'(busy), int'(e.busy));
        check("sb_gnt", int'(gnt), e.busy ? (1 << e.owner) : 0);
        if (e.busy) check("sb_gnt_id", int'(gnt_id), e.owner);
        check("sb_timeout", int'(timeout), int'(e.timeout));
      end
    end
  end

  task automatic step(input logic [N-1:0] r, input logic a, input logic s);
    req = r; ack = a; rst = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset then single request
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_timeout", int'(timeout), 0);
    step(4'b0100, 1'b0, 1'b0);
    check("t1_gnt", int'(gnt), 4'b0100);
    check("t1_gnt_id", int'(gnt_id), 2);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    check("t1_release", int'(busy), 0);

    // Pointer wrap and owner masking (ptr is now 3)
    step(4'b1001, 1'b0, 1'b0);
    check("t3_first", int'(gnt_id), 3);
    step(4'b1001, 1'b1, 1'b0);
    check("t3_masked", int'(gnt_id), 0);
    step(4'b0000, 1'b1, 1'b0);

    // Round-robin rotation with ack every third cycle
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    check("t2_first", int'(gnt_id), 0);
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      check("t2_rot_id", int'(gnt_id), (k + 1) % 4);
      check("t2_no_bubble", int'(busy), 1);
    end

    // Watchdog expiry and re-grant from idle
    do_reset();
    step(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b0);
    check("t4_held", int'(gnt), 4'b0010);
    step(4'b0010, 1'b0, 1'b0);
    check("t4_timeout", int'(timeout), 1);
    check("t4_released", int'(busy), 0);
    step(4'b0010, 1'b0, 1'b0);
    check("t4_regrant", int'(gnt_id), 1);
    check("t4_pulse_end", int'(timeout), 0);

    // Abandon, then reset while busy
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("t5_abandon", int'(busy), 0);
    check("t5_no_timeout", int'(timeout), 0);
    step(4'b1111, 1'b0, 1'b0);
    check("t5_ptr3", int'(gnt_id), 3);
    step(4'b1111, 1'b0, 1'b1);
    check("t5_rst_gnt", int'(gnt), 0);
    check("t5_rst_busy", int'(busy), 0);
    step(4'b1111, 1'b0, 1'b0);
    check("t5_post_rst", int'(gnt_id), 0);

    // Ack coinciding with watchdog expiry, then ack while idle
    do_reset();
    step(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    check("t6_ack_wins", int'(timeout), 0);
    step(4'b0000, 1'b1, 1'b0);
    check("t6_idle_ack", int'(busy), 0);
    step(4'b1111, 1'b0, 1'b0);
    check("t6_ptr2", int'(gnt_id), 2);

    // Randomized traffic with occasional abandon and reset
    begin
      logic [N-1:0] r;
      r = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int m = 0; m < N; m++) begin
          if (r[m]) begin
            if ($urandom_range(15) == 0) r[m] = 1'b0;
          end else if ($urandom_range(3) == 0) r[m] = 1'b1;
        end
        step(r, ($urandom_range(3) == 0), ($urandom_range(63) == 0));
      end
    end

    step('0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
